// File: rtl/mul_share_scheduler_pkg.sv
// Shared widths, product range and types for the time-multiplexed
// unsigned-5 x signed-3 multiplier.
package mul_share_scheduler_pkg;

  localparam int unsigned A_W = 5;
  localparam int unsigned B_W = 3;
  localparam int unsigned P_W = 8;

  localparam int PROD_MIN = -124;
  localparam int PROD_MAX = 93;

  typedef logic        [A_W-1:0] operand_a_t;
  typedef logic signed [B_W-1:0] operand_b_t;
  typedef logic signed [P_W-1:0] product_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Reference product: A is zero-extended, B sign-extended, full precision.
  function automatic product_t mul_ab(input operand_a_t a, input operand_b_t b);
    product_t a_ext;
    product_t b_ext;
    a_ext  = product_t'({1'b0, a});
    b_ext  = product_t'(b);
    mul_ab = a_ext * b_ext;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter.sv
// Combinational arbiter: first asserted request searching upward from ptr
// (round-robin) or from index 0 (fixed priority), wrapping at NUM_REQ.
module rr_grant_arbiter
  import mul_share_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               mode,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  int unsigned start;
  int unsigned idx;
  logic        found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    start  = mode ? 32'(ptr) : 32'd0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mul_share_scheduler.sv
// Shares one unsigned x signed multiplier among NUM_REQ requesters through an
// arbiter and a single registered, ID-tagged output stage with backpressure.
module mul_share_scheduler
  import mul_share_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned A_W     = mul_share_scheduler_pkg::A_W,
  parameter int unsigned B_W     = mul_share_scheduler_pkg::B_W,
  parameter int unsigned P_W     = mul_share_scheduler_pkg::P_W,
  parameter bit          RR      = 1'b1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*A_W-1:0]    req_a,
  input  logic [NUM_REQ*B_W-1:0]    req_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [P_W-1:0]     out_prod,
  output logic [ID_W-1:0]           out_id,
  output logic [15:0]               txn_cnt
);

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       ptr_next;
  logic [NUM_REQ-1:0]    grant;
  logic                  can_accept;
  logic                  accept;
  logic [A_W-1:0]        a_sel;
  logic signed [B_W-1:0] b_sel;
  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod;

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;

  // Gating the arbiter keeps req_ready a function of valid/state only,
  // and forces it low for the whole time reset is asserted.
  rr_grant_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .mode   (RR),
    .enable (can_accept && !ap_rst),
    .grant  (grant),
    .winner (winner)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    a_sel = req_a[32'(winner) * A_W +: A_W];
    b_sel = req_b[32'(winner) * B_W +: B_W];
    a_ext = P_W'({1'b0, a_sel});
    b_ext = P_W'(b_sel);
    prod  = a_ext * b_ext;
  end

  assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= EMPTY;
      out_prod <= '0;
      out_id   <= '0;
      txn_cnt  <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= FULL;
        end
        FULL: begin
          if (!accept && out_ready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
      if (accept) begin
        out_prod <= prod;
        out_id   <= winner;
        txn_cnt  <= txn_cnt + 16'd1;
        if (RR) ptr <= ptr_next;
      end
    end
  end

endmodule
